// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame size and parity helper.
// The host-side receiver reuses the frame constant and parity function.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_FIFO_DEPTH = 8;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// 8x8 synchronous FIFO for queued scan codes; drops writes when full and
// remembers that it did so until reset.
module ps2_tx_fifo
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty,
  output logic       dropped
);

  logic [7:0] mem_r [PS2_FIFO_DEPTH];
  logic [2:0] wptr_r;
  logic [2:0] rptr_r;
  logic [3:0] count_r;
  logic       dropped_r;
  logic       push_s;
  logic       pop_s;

  assign full    = (count_r == 4'd8);
  assign empty   = (count_r == 4'd0);
  assign push_s  = wr_en & ~full;
  assign pop_s   = rd_en & ~empty;
  assign rd_data = mem_r[rptr_r];
  assign dropped = dropped_r;

  // Pointer, occupancy and dropped-write bookkeeping.
  always_ff @(posedge clk) begin
    if (clrn) begin
      wptr_r    <= 3'd0;
      rptr_r    <= 3'd0;
      count_r   <= 4'd0;
      dropped_r <= 1'b0;
    end else begin
      if (push_s) wptr_r <= wptr_r + 3'd1;
      if (pop_s)  rptr_r <= rptr_r + 3'd1;
      if (wr_en && full) dropped_r <= 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wptr_r] <= wr_data;
  end

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device transmitter: queues scan codes and serialises them as 11-bit
// frames on a self-generated PS/2 clock, aborting and retrying on host inhibit.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HALF   = 50,
  parameter int GAP_CYCLES = 100
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  input  logic       ps2_inhibit,
  output logic       full,
  output logic       busy,
  output logic       tx_done,
  output logic       overflow,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam logic [15:0] HALF_LAST = 16'(CLK_HALF - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e  state_r, state_n;
  logic [15:0] cnt_r, cnt_n;
  logic [3:0]  bit_r, bit_n;
  logic [9:0]  shift_r, shift_n;
  logic [7:0]  hold_r, hold_n;
  logic        retry_r, retry_n;
  logic        ps2_clk_r, ps2_clk_n;
  logic        ps2_data_r, ps2_data_n;
  logic        tx_done_r, tx_done_n;
  logic        pop_s;
  logic [7:0]  head_s;
  logic        empty_s;

  ps2_tx_fifo u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .wr_data (data_in),
    .wr_en   (wr_en),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .full    (full),
    .empty   (empty_s),
    .dropped (overflow)
  );

  assign busy     = (state_r != ST_IDLE) | ~empty_s;
  assign tx_done  = tx_done_r;
  assign ps2_clk  = ps2_clk_r;
  assign ps2_data = ps2_data_r;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 16'd0;
      bit_r      <= 4'd0;
      shift_r    <= 10'd0;
      hold_r     <= 8'd0;
      retry_r    <= 1'b0;
      ps2_clk_r  <= 1'b1;
      ps2_data_r <= 1'b1;
      tx_done_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      bit_r      <= bit_n;
      shift_r    <= shift_n;
      hold_r     <= hold_n;
      retry_r    <= retry_n;
      ps2_clk_r  <= ps2_clk_n;
      ps2_data_r <= ps2_data_n;
      tx_done_r  <= tx_done_n;
    end
  end

  // Next-state logic; the shift register holds {stop, parity, d7..d0}.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    bit_n      = bit_r;
    shift_n    = shift_r;
    hold_n     = hold_r;
    retry_n    = retry_r;
    ps2_clk_n  = ps2_clk_r;
    ps2_data_n = ps2_data_r;
    tx_done_n  = 1'b0;
    pop_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = 1'b1;
        cnt_n      = 16'd0;
        if (!ps2_inhibit && (retry_r || !empty_s)) begin
          if (retry_r) begin
            shift_n = {1'b1, odd_parity(hold_r), hold_r};
          end else begin
            pop_s   = 1'b1;
            hold_n  = head_s;
            shift_n = {1'b1, odd_parity(head_s), head_s};
          end
          bit_n      = 4'd0;
          ps2_data_n = 1'b0;
          state_n    = ST_HIGH;
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_HIGH: begin
        if (ps2_inhibit && (bit_r != LAST_BIT)) begin
          ps2_clk_n  = 1'b1;
          ps2_data_n = 1'b1;
          retry_n    = 1'b1;
          cnt_n      = 16'd0;
          state_n    = ST_GAP;
        end else if (cnt_r == HALF_LAST) begin
          ps2_clk_n = 1'b0;
          cnt_n     = 16'd0;
          state_n   = ST_LOW;
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end

      ST_LOW: begin
        if (ps2_inhibit && (bit_r != LAST_BIT)) begin
          ps2_clk_n  = 1'b1;
          ps2_data_n = 1'b1;
          retry_n    = 1'b1;
          cnt_n      = 16'd0;
          state_n    = ST_GAP;
        end else if (cnt_r == HALF_LAST) begin
          cnt_n     = 16'd0;
          ps2_clk_n = 1'b1;
          if (bit_r == LAST_BIT) begin
            ps2_data_n = 1'b1;
            tx_done_n  = 1'b1;
            retry_n    = 1'b0;
            state_n    = ST_GAP;
          end else begin
            bit_n      = bit_r + 4'd1;
            ps2_data_n = shift_r[0];
            shift_n    = {1'b0, shift_r[9:1]};
            state_n    = ST_HIGH;
          end
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end

      ST_GAP: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = 1'b1;
        if (cnt_r == GAP_LAST) begin
          cnt_n   = 16'd0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end

      default: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = 1'b1;
        cnt_n      = 16'd0;
        state_n    = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench: a line monitor decodes frames at ps2_clk falling edges
// and compares them with frames built from the bytes the bench expects.
module tb_ps2_device_tx;

  localparam int CLK_HALF   = 4;
  localparam int GAP_CYCLES = 10;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] data_in;
  logic       wr_en;
  logic       ps2_inhibit;
  logic       full;
  logic       busy;
  logic       tx_done;
  logic       overflow;
  logic       ps2_clk;
  logic       ps2_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] rxf[$];
  logic [7:0]  expq[$];
  int          n_done = 0;
  int          nbits = 0;
  logic [10:0] acc = '0;
  logic        prev_clk = 1'b1;

  ps2_device_tx #(.CLK_HALF(CLK_HALF), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .ps2_inhibit (ps2_inhibit),
    .full        (full),
    .busy        (busy),
    .tx_done     (tx_done),
    .overflow    (overflow),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data)
  );

  always #5 clk = ~clk;

  // Host-side view of the line: sample data on each falling ps2_clk.
  always @(negedge clk) begin
    if (clrn || ps2_inhibit) begin
      nbits <= 0;
      acc   <= '0;
    end else if (prev_clk && !ps2_clk) begin
      if (nbits == 10) begin
        rxf.push_back({ps2_data, acc[9:0]});
        nbits <= 0;
        acc   <= '0;
      end else begin
        acc[nbits] <= ps2_data;
        nbits      <= nbits + 1;
      end
    end
    prev_clk <= ps2_clk;
    if (tx_done) n_done <= n_done + 1;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = ((ones % 2) == 0);
    f[10]  = 1'b1;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk(tag, 32'(k < 5000), 32'd1);
  endtask

  task automatic compare_rx(input string tag);
    int n;
    chk({tag, "_count"}, 32'(rxf.size()), 32'(expq.size()));
    n = (rxf.size() < expq.size()) ? rxf.size() : expq.size();
    for (int i = 0; i < n; i++) chk({tag, "_frame"}, 32'(rxf[i]), 32'(frame_of(expq[i])));
    rxf.delete();
    expq.delete();
  endtask

  task automatic write_seq(input logic [7:0] b);
    data_in = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int k;
    int done0;
    logic [7:0] b;
    clrn        = 1'b1;
    data_in     = 8'd0;
    wr_en       = 1'b0;
    ps2_inhibit = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);

    chk("rst_ps2_clk", 32'(ps2_clk), 32'd1);
    chk("rst_ps2_data", 32'(ps2_data), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // 0x1C: latency, frame length and bit pattern.
    done0   = n_done;
    data_in = 8'h1C;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("lat_data_still_high", 32'(ps2_data), 32'd1);
    @(negedge clk);
    chk("lat_data_low", 32'(ps2_data), 32'd0);
    k = 0;
    while (tx_done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("frame_len_1c", 32'(k), 32'd88);
    @(negedge clk);
    chk("tx_done_one_cycle", 32'(tx_done), 32'd0);
    expq.push_back(8'h1C);
    wait_idle("idle_1c");
    chk("frame_1c_literal", 32'(rxf.size() > 0 ? rxf[0] : 11'h0), 32'h438);
    compare_rx("rx_1c");
    chk("done_1c", 32'(n_done - done0), 32'd1);

    // 0xF0 alone: parity bit is 1.
    write_seq(8'hF0);
    expq.push_back(8'hF0);
    wait_idle("idle_f0");
    chk("frame_f0_literal", 32'(rxf.size() > 0 ? rxf[0] : 11'h0), 32'h7E0);
    compare_rx("rx_f0");

    // Back-to-back loopback sequence.
    done0 = n_done;
    data_in = 8'h1C; wr_en = 1'b1; @(negedge clk);
    data_in = 8'hF0; @(negedge clk);
    data_in = 8'h1C; @(negedge clk);
    wr_en = 1'b0;
    expq.push_back(8'h1C); expq.push_back(8'hF0); expq.push_back(8'h1C);
    wait_idle("idle_loop");
    compare_rx("rx_loop");
    chk("done_loop", 32'(n_done - done0), 32'd3);
    chk("loop_overflow", 32'(overflow), 32'd0);

    // Ten writes from idle: one leaves immediately, eight fill the FIFO.
    for (int i = 0; i < 10; i++) begin
      data_in = 8'(i + 1);
      wr_en   = 1'b1;
      @(negedge clk);
      if (i == 7) chk("full_after_8", 32'(full), 32'd0);
      if (i == 8) chk("full_after_9", 32'(full), 32'd1);
      if (i == 9) chk("overflow_after_10", 32'(overflow), 32'd1);
    end
    wr_en = 1'b0;
    for (int i = 1; i <= 9; i++) expq.push_back(8'(i));
    wait_idle("idle_ovf");
    compare_rx("rx_ovf");
    chk("overflow_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("overflow_cleared", 32'(overflow), 32'd0);

    // Inhibit during bit d5 of 0x5A, then whole-byte retry.
    done0 = n_done;
    data_in = 8'h5A; wr_en = 1'b1; @(negedge clk);
    data_in = 8'h33; @(negedge clk);
    wr_en = 1'b0;
    k = 0;
    while (nbits != 6 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("inh_reach_bit5", 32'(k < 200), 32'd1);
    repeat (CLK_HALF) @(negedge clk);
    chk("inh_data_before", 32'(ps2_data), 32'd0);
    ps2_inhibit = 1'b1;
    @(negedge clk);
    chk("inh_clk_high", 32'(ps2_clk), 32'd1);
    chk("inh_data_high", 32'(ps2_data), 32'd1);
    repeat (3 * GAP_CYCLES) @(negedge clk);
    chk("inh_no_frame", 32'(rxf.size()), 32'd0);
    ps2_inhibit = 1'b0;
    expq.push_back(8'h5A); expq.push_back(8'h33);
    wait_idle("idle_inh");
    compare_rx("rx_inh");
    chk("done_inh", 32'(n_done - done0), 32'd2);

    // Reset mid-frame with three bytes queued.
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h11 * 8'(i + 1);
      wr_en   = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (30) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    clrn = 1'b0;
    chk("mrst_clk", 32'(ps2_clk), 32'd1);
    chk("mrst_data", 32'(ps2_data), 32'd1);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_full", 32'(full), 32'd0);
    done0 = n_done;
    repeat (300) @(negedge clk);
    chk("mrst_no_frames", 32'(rxf.size()), 32'd0);
    chk("mrst_no_done", 32'(n_done - done0), 32'd0);

    // Randomised bursts that never exceed FIFO capacity.
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(8, 1);
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        expq.push_back(b);
        write_seq(b);
        repeat ($urandom_range(2, 0)) @(negedge clk);
      end
      wait_idle("idle_rand");
      compare_rx("rx_rand");
      chk("rand_overflow", 32'(overflow), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_device_tx.md
# ps2_device_tx

PS/2 device-side transmitter: accepts scan-code bytes from a byte-write interface, buffers them in an 8-deep FIFO, and serializes each one onto `ps2_clk`/`ps2_data` as an 11-bit PS/2 frame. Used as a keyboard emulator that drives the host-side PS/2 receiver in simulation and loopback tests. The block generates the PS/2 clock itself from `clk` and honours a host inhibit request.

## Interface
- `CLK_HALF`, default 50: `clk` cycles per PS/2 clock half-period (≥2).
- `GAP_CYCLES`, default 100: idle cycles (clk and data high) after each frame (≥1).
- `clk`  in  1  system clock; all logic on rising edge.
- `clrn`  in  1  reset, synchronous, active-high.
- `data_in`  in  8  scan-code byte to queue.
- `wr_en`  in  1  write strobe; one byte per cycle.
- `ps2_inhibit`  in  1  host inhibit, active-high.
- `full`  out  1  FIFO holds 8 bytes.
- `busy`  out  1  not IDLE, or FIFO non-empty.
- `tx_done`  out  1  one-cycle pulse when a frame's stop bit completes.
- `overflow`  out  1  sticky: a write was dropped.
- `ps2_clk`  out  1  generated PS/2 clock; idle high.
- `ps2_data`  out  1  serial data; idle high.

## Operation
- Frame: start 0, d0..d7 LSB first, odd parity (`~^data`), stop 1.
- FIFO: 8×8, 3-bit pointers plus a 4-bit count. A write when `full`=1 is dropped and sets `overflow`. Write and pop in the same cycle are both performed. `overflow` is cleared only by reset.
- States: IDLE, HIGH, LOW, GAP.
  - **IDLE** (clk=1, data=1): if `ps2_inhibit`=0 and (retry flag or FIFO non-empty):
    - Load the shift register from the hold register (retry), or pop the FIFO head into the hold register and shift register.
    - Set `bit_cnt`=0 and `ps2_data`←0, then go to HIGH.
  - **HIGH**: `ps2_clk`=1 for CLK_HALF cycles, then `ps2_clk`←0 and go to LOW. This is the falling edge the host samples on.
  - **LOW**: `ps2_clk`=0 for CLK_HALF cycles, then:
    - If `bit_cnt`=10: `ps2_clk`←1, `ps2_data`←1, pulse `tx_done`, clear the retry flag, go to GAP.
    - Otherwise: increment `bit_cnt`, drive the next bit on `ps2_data`, `ps2_clk`←1, go to HIGH.
  - **GAP**: lines high for GAP_CYCLES, then IDLE.
- Inhibit mid-frame: if `ps2_inhibit`=1 in HIGH or LOW with `bit_cnt`<10:
  - Next cycle both lines go high, the retry flag is set, and the state goes to GAP.
  - The byte is retransmitted whole after inhibit releases and GAP expires.
  - If inhibit arrives while `bit_cnt`=10, the frame completes normally.
- Reset: all state cleared, FIFO emptied, retry flag cleared. Takes effect on the next edge even mid-frame.

## Timing
- Output reset values: `ps2_clk`=1, `ps2_data`=1, `full`=0, `busy`=0, `tx_done`=0, `overflow`=0.
- All outputs are registered; no combinational paths from inputs to outputs.
- Latency: `wr_en` sampled at edge t with FIFO empty and IDLE → `ps2_data`=0 after edge t+1. The first falling edge of `ps2_clk` comes CLK_HALF cycles later.
- Each bit's data changes only at the start of a HIGH phase. It is stable CLK_HALF cycles before and CLK_HALF cycles after the falling edge.
- Frame length: 22·CLK_HALF cycles. Frame-to-frame period: 22·CLK_HALF + GAP_CYCLES + 1 (IDLE cycle).
- `tx_done` is asserted for exactly one cycle, in the cycle after the final LOW phase ends.

## Structure
- Shared package `ps2_pkg`: state enum (IDLE/HIGH/LOW/GAP), `PS2_FRAME_BITS`=11, and an odd-parity function. The host receiver reuses the frame constant and parity function.
- One sub-module, `ps2_tx_fifo` (8×8 synchronous FIFO with count, full/empty, and dropped-write flag). The FSM, half-period counter, shift register and hold register live in the top level.

## Test plan
- Write 0x1C, CLK_HALF=4 → line bits at falling edges 0,0,0,1,1,1,0,0,0,0,1 (parity 0). `tx_done` pulses once, 88 cycles after `ps2_data` first falls.
- Write 0xF0 → bits 0,0,0,0,0,1,1,1,1,1,1 (parity 1).
- Loopback into the host PS/2 receiver: write 0x1C, 0xF0, 0x1C back-to-back → receiver outputs the same three bytes in order, with no overflow and no parity rejects.
- 10 back-to-back writes 0x01..0x0A starting from idle → `full`=1 after the 9th, 10th write (0x0A) dropped, `overflow`=1. Exactly 9 frames (0x01..0x09) sent.
- Assert `ps2_inhibit` during bit 5 of 0x5A → lines high next cycle. Release → after GAP, 0x5A is sent in full once, and the next FIFO byte follows.
- Assert `clrn` mid-frame with 3 bytes queued → next cycle lines high, `busy`=0, `full`=0. No further frames until new writes.
